// File: rtl/ex_stage_pkg.sv
// Shared encodings for the MIPS execute stage: ALUOp values, R-type funct codes,
// 4-bit ALU control codes and bit positions of the WB/M/exe control fields.
package ex_stage_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ZERO  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_NOR  = 4'b1100,
    ALU_ZERO = 4'b1111
  } alu_ctrl_e;

  localparam int WB_REGWRITE  = 1;
  localparam int WB_MEMTOREG  = 0;
  localparam int M_BRANCH     = 2;
  localparam int M_MEMREAD    = 1;
  localparam int M_MEMWRITE   = 0;
  localparam int EXE_REGDST   = 3;
  localparam int EXE_ALUOP_HI = 2;
  localparam int EXE_ALUOP_LO = 1;
  localparam int EXE_ALUSRC   = 0;

  // ALU control from ALUOp and funct; unknown funct codes fall back to ZERO.
  function automatic alu_ctrl_e alu_ctrl_decode(input logic [1:0] alu_op,
                                                input logic [5:0] funct);
    alu_ctrl_e ctrl;
    ctrl = ALU_ZERO;
    case (alu_op)
      ALUOP_ADD:  ctrl = ALU_ADD;
      ALUOP_SUB:  ctrl = ALU_SUB;
      ALUOP_ZERO: ctrl = ALU_ZERO;
      default: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_ADD;
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_SLT: ctrl = ALU_SLT;
          FUNCT_NOR: ctrl = ALU_NOR;
          default:   ctrl = ALU_ZERO;
        endcase
      end
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU of the execute stage. Add/sub wrap, SLT is a signed compare.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  alu_ctrl_e              ctrl_i,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  output logic        [DW-1:0]   result_o,
  output logic                   zero_o
);

  // Select the operation named by the ALU control code.
  always_comb begin
    result_o = '0;
    case (ctrl_i)
      ALU_ADD: result_o = a_i + b_i;
      ALU_SUB: result_o = a_i - b_i;
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_NOR: result_o = ~(a_i | b_i);
      ALU_SLT: result_o = {{(DW-1){1'b0}}, (a_i < b_i)};
      default: result_o = '0;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: operand mux, ALU, branch-target adder, destination
// register select, and the EX/MEM latch with stall (hold) and flush (bubble).
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [1:0]    WB_in,
  input  logic [2:0]    M_in,
  input  logic [3:0]    exe_in,
  input  logic [DW-1:0] NPC_in,
  input  logic [DW-1:0] RD1_in,
  input  logic [DW-1:0] RD2_in,
  input  logic [DW-1:0] Sign_in,
  input  logic [RW-1:0] Instr_20_16_in,
  input  logic [RW-1:0] Instr_15_11_in,
  output logic [1:0]    WB_out,
  output logic [2:0]    M_out,
  output logic [DW-1:0] add_result_out,
  output logic          zero_out,
  output logic [DW-1:0] alu_result_out,
  output logic [DW-1:0] rdata2_out,
  output logic [RW-1:0] muxout_out
);

  alu_ctrl_e            alu_ctrl;
  logic signed [DW-1:0] alu_a;
  logic signed [DW-1:0] alu_b;
  logic        [DW-1:0] alu_result;
  logic                 alu_zero;
  logic        [DW-1:0] branch_target;
  logic        [RW-1:0] dest_reg;

  logic [1:0]    wb_q,     wb_d;
  logic [2:0]    m_q,      m_d;
  logic [DW-1:0] add_q,    add_d;
  logic          zero_q,   zero_d;
  logic [DW-1:0] alu_q,    alu_d;
  logic [DW-1:0] rdata2_q, rdata2_d;
  logic [RW-1:0] mux_q,    mux_d;

  assign alu_ctrl      = alu_ctrl_decode(exe_in[EXE_ALUOP_HI:EXE_ALUOP_LO], Sign_in[5:0]);
  assign alu_a         = RD1_in;
  assign alu_b         = exe_in[EXE_ALUSRC] ? Sign_in : RD2_in;
  assign branch_target = NPC_in + {Sign_in[DW-3:0], 2'b00};
  assign dest_reg      = exe_in[EXE_REGDST] ? Instr_15_11_in : Instr_20_16_in;

  ex_alu #(.DW(DW)) u_alu (
    .ctrl_i   (alu_ctrl),
    .a_i      (alu_a),
    .b_i      (alu_b),
    .result_o (alu_result),
    .zero_o   (alu_zero)
  );

  // Next latch contents: flush bubbles the control fields, stall holds everything.
  always_comb begin
    wb_d     = wb_q;
    m_d      = m_q;
    add_d    = add_q;
    zero_d   = zero_q;
    alu_d    = alu_q;
    rdata2_d = rdata2_q;
    mux_d    = mux_q;
    if (flush) begin
      wb_d = '0;
      m_d  = '0;
    end else if (!stall) begin
      wb_d = WB_in;
      m_d  = M_in;
    end
    if (flush || !stall) begin
      add_d    = branch_target;
      zero_d   = alu_zero;
      alu_d    = alu_result;
      rdata2_d = RD2_in;
      mux_d    = dest_reg;
    end
  end

  // EX/MEM latch with synchronous active-low clear of every field.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q     <= '0;
      m_q      <= '0;
      add_q    <= '0;
      zero_q   <= 1'b0;
      alu_q    <= '0;
      rdata2_q <= '0;
      mux_q    <= '0;
    end else begin
      wb_q     <= wb_d;
      m_q      <= m_d;
      add_q    <= add_d;
      zero_q   <= zero_d;
      alu_q    <= alu_d;
      rdata2_q <= rdata2_d;
      mux_q    <= mux_d;
    end
  end

  assign WB_out         = wb_q;
  assign M_out          = m_q;
  assign add_result_out = add_q;
  assign zero_out       = zero_q;
  assign alu_result_out = alu_q;
  assign rdata2_out     = rdata2_q;
  assign muxout_out     = mux_q;

endmodule
